bloom_filter_hashes_11b: RTL and testbench

Computes seven independent 11-bit hash indices from one 72-bit key for the Bloom filter's BRAM-based bit array; each index addresses one of seven 2048-entry bit banks. Each hash is a rotate, XOR-fold and seed-XOR of the key: cheap, deterministic and easy to model in the bench. The block sits between the key-extraction front end and the bank read/write logic. Outputs are registered and qualified by a valid strobe.

---
 rtl/bloom_hash_pkg.sv | 26 ++
 rtl/bloom_hash_fold.sv | 48 ++++
 rtl/bloom_filter_hashes_11b.sv | 109 ++++++++++
 tb/tb_bloom_filter_hashes_11b.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_hash_pkg.sv
// Shared constants, types and the key-rotation helper for the Bloom filter hash block.
package bloom_hash_pkg;

    localparam int KEY_W     = 72;
    localparam int HASH_W    = 11;
    localparam int NUM_HASH  = 7;
    localparam int NUM_CHUNK = 7;
    localparam int EXT_W     = NUM_CHUNK * HASH_W;
    localparam int LO_CHUNKS = 4;

    typedef logic [HASH_W-1:0] hash_t;

    localparam int ROT [NUM_HASH] = '{0, 7, 13, 19, 29, 37, 43};

    localparam hash_t SEED [NUM_HASH] = '{
        11'h5A3, 11'h2C7, 11'h71E, 11'h0B9, 11'h64D, 11'h3F2, 11'h18A
    };

    // Rotate left within the key width; the doubled key makes r = 0 need no special case.
    function automatic logic [KEY_W-1:0] rotl72(input logic [KEY_W-1:0] key, input int r);
        logic [2*KEY_W-1:0] dbl;
        dbl = {key, key};
        return dbl[2*KEY_W-1-r -: KEY_W];
    endfunction

endpackage

// File: rtl/bloom_hash_fold.sv
// One hash lane: rotate the key, zero-extend to seven chunks and XOR-fold them.
// With BLOOM_HASH_PIPE_EN the two partial folds are exposed separately for pipelining.
module bloom_hash_fold
    import bloom_hash_pkg::KEY_W, bloom_hash_pkg::HASH_W, bloom_hash_pkg::EXT_W,
           bloom_hash_pkg::NUM_CHUNK, bloom_hash_pkg::LO_CHUNKS, bloom_hash_pkg::hash_t,
           bloom_hash_pkg::rotl72;
#(
    parameter int    ROT  = 0,
    parameter hash_t SEED = '0
)
(
    input  logic [KEY_W-1:0]  key_i,
`ifdef BLOOM_HASH_PIPE_EN
    output logic [HASH_W-1:0] part_lo_o,
    output logic [HASH_W-1:0] part_hi_o,
    output logic [HASH_W-1:0] seed_o
`else
    output logic [HASH_W-1:0] fold_o
`endif
);

    logic [EXT_W-1:0] ext;
    hash_t            lo;
    hash_t            hi;

    assign ext = {{(EXT_W-KEY_W){1'b0}}, rotl72(key_i, ROT)};

    always_comb begin
        lo = '0;
        hi = '0;
        for (int k = 0; k < LO_CHUNKS; k++) begin
            lo = lo ^ ext[k*HASH_W +: HASH_W];
        end
        for (int k = LO_CHUNKS; k < NUM_CHUNK; k++) begin
            hi = hi ^ ext[k*HASH_W +: HASH_W];
        end
    end

`ifdef BLOOM_HASH_PIPE_EN
    // The seed travels with the partials so the second stage can finish the hash.
    assign part_lo_o = lo;
    assign part_hi_o = hi;
    assign seed_o    = SEED;
`else
    assign fold_o = lo ^ hi ^ SEED;
`endif

endmodule

// File: rtl/bloom_filter_hashes_11b.sv
// Seven 11-bit Bloom filter bank indices from one 72-bit key, registered with a valid strobe.
// Define BLOOM_HASH_PIPE_EN for a two-stage (latency 2) build; default is latency 1.
module bloom_filter_hashes_11b
    import bloom_hash_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [KEY_W-1:0]  data_in,
    output logic              valid_out,
    output logic [HASH_W-1:0] hash_0,
    output logic [HASH_W-1:0] hash_1,
    output logic [HASH_W-1:0] hash_2,
    output logic [HASH_W-1:0] hash_3,
    output logic [HASH_W-1:0] hash_4,
    output logic [HASH_W-1:0] hash_5,
    output logic [HASH_W-1:0] hash_6
);

    hash_t hash_q [NUM_HASH];
    hash_t hash_d [NUM_HASH];
    logic  valid_q;

`ifdef BLOOM_HASH_PIPE_EN
    hash_t lo_d   [NUM_HASH];
    hash_t hi_d   [NUM_HASH];
    hash_t seed_w [NUM_HASH];
    hash_t lo_q   [NUM_HASH];
    hash_t hi_q   [NUM_HASH];
    logic  s1_valid_q;

    for (genvar g = 0; g < NUM_HASH; g++) begin : g_fold
        bloom_hash_fold #(
            .ROT  (ROT[g]),
            .SEED (SEED[g])
        ) u_fold (
            .key_i     (data_in),
            .part_lo_o (lo_d[g]),
            .part_hi_o (hi_d[g]),
            .seed_o    (seed_w[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_HASH; i++) begin
            hash_d[i] = lo_q[i] ^ hi_q[i] ^ seed_w[i];
        end
    end

    // Stage 1 captures the partial folds only for valid keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '{default: '0};
            hi_q       <= '{default: '0};
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                lo_q <= lo_d;
                hi_q <= hi_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hash_q  <= '{default: '0};
        end else begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                hash_q <= hash_d;
            end
        end
    end
`else
    for (genvar g = 0; g < NUM_HASH; g++) begin : g_fold
        bloom_hash_fold #(
            .ROT  (ROT[g]),
            .SEED (SEED[g])
        ) u_fold (
            .key_i  (data_in),
            .fold_o (hash_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hash_q  <= '{default: '0};
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                hash_q <= hash_d;
            end
        end
    end
`endif

    assign valid_out = valid_q;
    assign hash_0    = hash_q[0];
    assign hash_1    = hash_q[1];
    assign hash_2    = hash_q[2];
    assign hash_3    = hash_q[3];
    assign hash_4    = hash_q[4];
    assign hash_5    = hash_q[5];
    assign hash_6    = hash_q[6];

endmodule

// File: tb/tb_bloom_filter_hashes_11b.sv
// Self-checking bench for bloom_filter_hashes_11b: fixed vectors, back-to-back, random and reset cases
// checked against a bit-by-bit reference model; works in both BLOOM_HASH_PIPE_EN builds.
module tb_bloom_filter_hashes_11b;

`ifdef BLOOM_HASH_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int          ROT_TB  [7] = '{0, 7, 13, 19, 29, 37, 43};
    localparam logic [10:0] SEED_TB [7] = '{11'h5A3, 11'h2C7, 11'h71E, 11'h0B9, 11'h64D, 11'h3F2, 11'h18A};
    localparam logic [10:0] VEC_EXP [3][7] = '{
        '{11'h5A3, 11'h2C7, 11'h71E, 11'h0B9, 11'h64D, 11'h3F2, 11'h18A},
        '{11'h59C, 11'h2F8, 11'h721, 11'h086, 11'h672, 11'h3CD, 11'h1B5},
        '{11'h5A2, 11'h247, 11'h71A, 11'h1B9, 11'h6CD, 11'h3E2, 11'h58A}
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [71:0] data_in = '0;
    logic        valid_out;
    logic [10:0] hash_0, hash_1, hash_2, hash_3, hash_4, hash_5, hash_6;
    logic [10:0] hashObs [7];

    int compared = 0;
    int mismatched = 0;

    logic        expValid;
    logic [10:0] expHash [7];
    bit          pendV [$];
    logic [71:0] pendK [$];

    always #5 clk = ~clk;

    bloom_filter_hashes_11b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .hash_0    (hash_0),
        .hash_1    (hash_1),
        .hash_2    (hash_2),
        .hash_3    (hash_3),
        .hash_4    (hash_4),
        .hash_5    (hash_5),
        .hash_6    (hash_6)
    );

    assign hashObs[0] = hash_0;
    assign hashObs[1] = hash_1;
    assign hashObs[2] = hash_2;
    assign hashObs[3] = hash_3;
    assign hashObs[4] = hash_4;
    assign hashObs[5] = hash_5;
    assign hashObs[6] = hash_6;

    // Each set key bit lands at (j + rot) mod 72 and then at that position mod 11 of the fold.
    function automatic logic [10:0] refHash(input int i, input logic [71:0] k);
        logic [10:0] h;
        int          pos;
        h = SEED_TB[i];
        for (int j = 0; j < 72; j++) begin
            if (k[j]) begin
                pos = ((j + ROT_TB[i]) % 72) % 11;
                h[pos] = ~h[pos];
            end
        end
        return h;
    endfunction

    function automatic logic [71:0] randKey();
        logic [95:0] r96;
        r96 = {$urandom(), $urandom(), $urandom()};
        return r96[71:0];
    endfunction

    task automatic modelReset();
        pendV.delete();
        pendK.delete();
        for (int n = 0; n < LAT - 1; n++) begin
            pendV.push_back(1'b0);
            pendK.push_back('0);
        end
        expValid = 1'b0;
        for (int i = 0; i < 7; i++) expHash[i] = '0;
    endtask

    // Drive one cycle of input, advance past the edge and update the expected outputs.
    task automatic applyStimulus(input bit v, input logic [71:0] k);
        logic [71:0] kk;
        valid_in = v;
        data_in  = k;
        @(posedge clk);
        #1;
        pendV.push_back(v);
        pendK.push_back(k);
        expValid = pendV.pop_front();
        kk = pendK.pop_front();
        if (expValid) begin
            for (int i = 0; i < 7; i++) expHash[i] = refHash(i, kk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = randKey();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset valid_out: got %b want 0", valid_out);
        end
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (hashObs[i] !== 11'h000) begin
                mismatched++;
                $display("[TB] FAIL reset hash_%0d: got %h want 000", i, hashObs[i]);
            end
        end
        valid_in = 1'b0;
        rst_n    = 1'b1;
        modelReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, randKey());
            compared++;
            if (valid_out !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_after_reset valid_out c%0d: got %b want 0", c, valid_out);
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== 11'h000) begin
                    mismatched++;
                    $display("[TB] FAIL idle_after_reset hash_%0d c%0d: got %h want 000", i, c, hashObs[i]);
                end
            end
        end
    endtask

    task automatic test_vectors();
        logic [71:0] keys [3];
        keys[0] = 72'h0;
        keys[1] = {72{1'b1}};
        keys[2] = 72'h1;
        for (int v = 0; v < 3; v++) begin
            applyStimulus(1'b1, keys[v]);
            for (int w = 0; w < LAT - 1; w++) applyStimulus(1'b0, randKey());
            compared++;
            if (valid_out !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL vector%0d valid_out: got %b want 1", v, valid_out);
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== VEC_EXP[v][i]) begin
                    mismatched++;
                    $display("[TB] FAIL vector%0d hash_%0d: got %h want %h", v, i, hashObs[i], VEC_EXP[v][i]);
                end
            end
            applyStimulus(1'b0, randKey());
            compared++;
            if (valid_out !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL vector%0d_hold valid_out: got %b want 0", v, valid_out);
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== VEC_EXP[v][i]) begin
                    mismatched++;
                    $display("[TB] FAIL vector%0d_hold hash_%0d: got %h want %h", v, i, hashObs[i], VEC_EXP[v][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] seq [3];
        int          seen;
        seq[0] = 72'h0;
        seq[1] = 72'h1;
        seq[2] = {72{1'b1}};
        seen = 0;
        for (int s = 0; s < 3 + LAT + 1; s++) begin
            if (s < 3) applyStimulus(1'b1, seq[s]);
            else       applyStimulus(1'b0, randKey());
            compared++;
            if (valid_out !== expValid) begin
                mismatched++;
                $display("[TB] FAIL b2b valid_out step%0d: got %b want %b", s, valid_out, expValid);
            end
            if (valid_out === 1'b1) begin
                compared++;
                if (seen > 2 || hashObs[0] !== VEC_EXP[(seen == 0) ? 0 : ((seen == 1) ? 2 : 1)][0]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b order step%0d: got hash_0 %h as result %0d", s, hashObs[0], seen);
                end
                seen++;
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== expHash[i]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b hash_%0d step%0d: got %h want %h", i, s, hashObs[i], expHash[i]);
                end
            end
        end
        compared++;
        if (seen !== 3) begin
            mismatched++;
            $display("[TB] FAIL b2b valid_count: got %0d want 3", seen);
        end
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (hashObs[i] !== VEC_EXP[1][i]) begin
                mismatched++;
                $display("[TB] FAIL b2b final hash_%0d: got %h want %h", i, hashObs[i], VEC_EXP[1][i]);
            end
        end
    endtask

    task automatic test_random();
        logic [71:0] k;
        bit          v;
        for (int c = 0; c < 300; c++) begin
            if (c == 0)      begin k = 72'h123456789ABCDEF;  v = 1'b1; end
            else if (c == 1) begin k = 72'hCAFEBABEDEAD123;  v = 1'b1; end
            else             begin k = randKey(); v = ($urandom_range(0, 3) != 0); end
            applyStimulus(v, k);
            compared++;
            if (valid_out !== expValid) begin
                mismatched++;
                $display("[TB] FAIL random valid_out c%0d: got %b want %b", c, valid_out, expValid);
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== expHash[i]) begin
                    mismatched++;
                    $display("[TB] FAIL random hash_%0d c%0d: got %h want %h", i, c, hashObs[i], expHash[i]);
                end
            end
        end
    endtask

    task automatic test_reset_in_flight();
        applyStimulus(1'b1, randKey());
        compared++;
        if (valid_out !== expValid) begin
            mismatched++;
            $display("[TB] FAIL inflight pre valid_out: got %b want %b", valid_out, expValid);
        end
        valid_in = 1'b1;
        data_in  = randKey();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if (valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL inflight async valid_out: got %b want 0", valid_out);
        end
        for (int i = 0; i < 7; i++) begin
            compared++;
            if (hashObs[i] !== 11'h000) begin
                mismatched++;
                $display("[TB] FAIL inflight async hash_%0d: got %h want 000", i, hashObs[i]);
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n    = 1'b1;
        modelReset();
        for (int c = 0; c < LAT + 2; c++) begin
            applyStimulus(1'b0, randKey());
            compared++;
            if (valid_out !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL inflight drain valid_out c%0d: got %b want 0", c, valid_out);
            end
            for (int i = 0; i < 7; i++) begin
                compared++;
                if (hashObs[i] !== 11'h000) begin
                    mismatched++;
                    $display("[TB] FAIL inflight drain hash_%0d c%0d: got %h want 000", i, c, hashObs[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
